hi_lo_multiply_divide_controller: RTL and testbench
===================================================

Name: hi_lo_multiply_divide_controller

Overview:
Iterative multiply/divide sequencer that owns the HI/LO registers of the pipelined MIPS core. It accepts MULT/MULTU/DIV/DIVU from the execute stage and runs a 32-iteration shift-add or restoring-divide engine. It requests a stall of fetch/decode and a bubble into the decode/execute pipeline register when a later instruction needs HI/LO or the engine while the engine is busy.

Parameters:
ITERATIONS, 32, engine iterations per operation; must equal the data width.
DATA_WIDTH, 32, operand and HI/LO width.

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
start_execute  input  1  launch an operation this cycle
operation_execute  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
operand_a_execute  input  32  Rs value (multiplicand or dividend)
operand_b_execute  input  32  Rt value (multiplier or divisor)
hi_write_execute  input  1  MTHI
lo_write_execute  input  1  MTLO
write_data_execute  input  32  MTHI/MTLO data
hi_lo_access_decode  input  1  decode holds MFHI/MFLO/MTHI/MTLO/MULT*/DIV*
hi  output  32  HI register
lo  output  32  LO register
busy  output  1  engine running
stall_decode  output  1  freeze the fetch/decode register and PC
clear_execute  output  1  clear into the decode/execute register (bubble)

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high.
- Reset: state IDLE; hi=0, lo=0, busy=0. The stall and clear outputs follow busy, so both are 0. Reset mid-operation aborts the operation and discards the result.
- FSM states: IDLE, CALC, FINISH.
  - IDLE to CALC: start_execute=1 at edge N. Operands are latched and the iteration counter is set to 0.
  - CALC: one iteration per edge. After the 32nd iteration (edge N+32) the FSM moves to FINISH.
  - FINISH: at edge N+33, hi/lo are written and the FSM returns to IDLE.
- busy = (state != IDLE). It is high for exactly 33 cycles after the start edge. New hi/lo are visible in the first cycle that busy=0.
- start_execute while busy is ignored. The stall logic guarantees this cannot occur legally.
- Signed operands: both operands are converted to magnitudes, the unsigned engine runs, and signs are fixed in FINISH.
  - MULT: {hi,lo} = 64-bit signed product.
  - MULTU: {hi,lo} = 64-bit unsigned product.
  - DIV: lo = quotient truncated toward zero; hi = remainder, which takes the sign of the dividend.
  - DIVU: unsigned quotient and remainder.
- Divide by zero (DIV or DIVU): lo=0xFFFFFFFF, hi=dividend. The operation still takes the full 33 cycles.
- Overflow, DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0x00000000.
- MTHI/MTLO:
  - Written at the edge when state==IDLE.
  - Ignored while busy.
  - If an MTHI/MTLO write and start_execute occur in the same IDLE cycle, the write takes effect and the operation launches. The operation result later overwrites both registers.
- stall_decode = busy & hi_lo_access_decode, combinational.
- clear_execute = stall_decode. The dependent instruction is held in decode and a bubble enters execute.
- In FINISH, stall_decode is still 1. The held instruction advances on the first cycle busy=0 and reads the new hi/lo.
- The hi/lo outputs hold their old values throughout CALC and FINISH, until the write at the FINISH edge.

Test Plan:
- Reset, then MULT with a=0xFFFFFFFD (-3), b=5 -> busy high 33 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- MULTU with a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. Repeat as MULT -> hi=0, lo=1.
- DIV with a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU with a=7, b=0 -> lo=0xFFFFFFFF, hi=7. DIV with 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- Start a MULT, then raise hi_lo_access_decode 5 cycles later -> stall_decode=clear_execute=1 until busy falls (cycle 33), then 0. hi_lo_access_decode with busy=0 -> no stall.
- MTHI 0x12345678 while busy -> hi unchanged. MTLO 0xCAFEF00D in IDLE -> lo=0xCAFEF00D next cycle.
- Assert reset at cycle 10 of a DIV -> next cycle busy=0, hi=lo=0, stalls 0. A new MULT 3*4 then gives lo=12, hi=0.

Source files
------------

// File: rtl/hi_lo_multiply_divide_controller.sv
// HI/LO owner for the MIPS core: iterative MULT/MULTU/DIV/DIVU engine
// (shift-add multiply, restoring divide) plus decode stall/bubble requests.
module hi_lo_multiply_divide_controller #(
   parameter int ITERATIONS = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start_execute,
   input  logic [1:0]            operation_execute,
   input  logic [DATA_WIDTH-1:0] operand_a_execute,
   input  logic [DATA_WIDTH-1:0] operand_b_execute,
   input  logic                  hi_write_execute,
   input  logic                  lo_write_execute,
   input  logic [DATA_WIDTH-1:0] write_data_execute,
   input  logic                  hi_lo_access_decode,
   output logic [DATA_WIDTH-1:0] hi,
   output logic [DATA_WIDTH-1:0] lo,
   output logic                  busy,
   output logic                  stall_decode,
   output logic                  clear_execute
);
   localparam int W  = DATA_WIDTH;
   localparam int CW = $clog2(ITERATIONS);

   typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;

   state_t         state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic           div_q, div_d;
   logic           qneg_q, qneg_d;
   logic           rneg_q, rneg_d;
   logic           bzero_q, bzero_d;
   logic [W-1:0]   a_q, a_d;
   logic [W-1:0]   b_q, b_d;
   logic [W-1:0]   acc_hi_q, acc_hi_d;
   logic [W-1:0]   acc_lo_q, acc_lo_d;
   logic [W-1:0]   hi_q, hi_d;
   logic [W-1:0]   lo_q, lo_d;

   logic           sgn_op;
   logic [W-1:0]   mag_a, mag_b;
   logic [W:0]     mul_sum;
   logic [W:0]     div_sh;
   logic           div_ge;
   logic [W-1:0]   div_rem;
   logic [2*W-1:0] prod;
   logic [2*W-1:0] prod_fix;

   // MULT and DIV (op[0]==0) run on magnitudes; signs are restored at the end
   assign sgn_op = ~operation_execute[0];
   assign mag_a  = (sgn_op && operand_a_execute[W-1]) ? -operand_a_execute
                                                      : operand_a_execute;
   assign mag_b  = (sgn_op && operand_b_execute[W-1]) ? -operand_b_execute
                                                      : operand_b_execute;

   assign mul_sum  = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, b_q} : '0);
   assign div_sh   = {acc_hi_q, acc_lo_q[W-1]};
   assign div_ge   = div_sh >= {1'b0, b_q};
   assign div_rem  = div_ge ? (div_sh[W-1:0] - b_q) : div_sh[W-1:0];
   assign prod     = {acc_hi_q, acc_lo_q};
   assign prod_fix = qneg_q ? -prod : prod;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      div_d    = div_q;
      qneg_d   = qneg_q;
      rneg_d   = rneg_q;
      bzero_d  = bzero_q;
      a_d      = a_q;
      b_d      = b_q;
      acc_hi_d = acc_hi_q;
      acc_lo_d = acc_lo_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      unique case (state_q)
         IDLE: begin
            if (hi_write_execute) hi_d = write_data_execute;
            if (lo_write_execute) lo_d = write_data_execute;
            if (start_execute) begin
               state_d  = CALC;
               cnt_d    = '0;
               div_d    = operation_execute[1];
               qneg_d   = sgn_op & (operand_a_execute[W-1] ^ operand_b_execute[W-1]);
               rneg_d   = sgn_op & operand_a_execute[W-1];
               bzero_d  = (operand_b_execute == '0);
               a_d      = operand_a_execute;
               b_d      = mag_b;
               acc_hi_d = '0;
               acc_lo_d = mag_a;
            end
         end
         CALC: begin
            if (div_q) begin
               acc_hi_d = div_rem;
               acc_lo_d = {acc_lo_q[W-2:0], div_ge};
            end else begin
               {acc_hi_d, acc_lo_d} = {mul_sum, acc_lo_q[W-1:1]};
            end
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(ITERATIONS - 1)) state_d = FINISH;
         end
         FINISH: begin
            state_d = IDLE;
            if (!div_q) begin
               {hi_d, lo_d} = prod_fix;
            end else if (bzero_q) begin
               hi_d = a_q;
               lo_d = '1;
            end else begin
               lo_d = qneg_q ? -acc_lo_q : acc_lo_q;
               hi_d = rneg_q ? -acc_hi_q : acc_hi_q;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         div_q    <= 1'b0;
         qneg_q   <= 1'b0;
         rneg_q   <= 1'b0;
         bzero_q  <= 1'b0;
         a_q      <= '0;
         b_q      <= '0;
         acc_hi_q <= '0;
         acc_lo_q <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         div_q    <= div_d;
         qneg_q   <= qneg_d;
         rneg_q   <= rneg_d;
         bzero_q  <= bzero_d;
         a_q      <= a_d;
         b_q      <= b_d;
         acc_hi_q <= acc_hi_d;
         acc_lo_q <= acc_lo_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
      end
   end

   assign hi            = hi_q;
   assign lo            = lo_q;
   assign busy          = (state_q != IDLE);
   assign stall_decode  = busy & hi_lo_access_decode;
   assign clear_execute = stall_decode;

endmodule

// File: tb/tb_hi_lo_multiply_divide_controller.sv
// Scoreboard bench for hi_lo_multiply_divide_controller: random and
// directed operations, stall/bubble timing, MTHI/MTLO and reset abort.
module tb_hi_lo_multiply_divide_controller;
   logic        clk = 1'b0;
   logic        reset;
   logic        start_execute;
   logic [1:0]  operation_execute;
   logic [31:0] operand_a_execute;
   logic [31:0] operand_b_execute;
   logic        hi_write_execute;
   logic        lo_write_execute;
   logic [31:0] write_data_execute;
   logic        hi_lo_access_decode;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        busy;
   logic        stall_decode;
   logic        clear_execute;

   hi_lo_multiply_divide_controller #(.ITERATIONS(32), .DATA_WIDTH(32)) dut (
      .clk                 (clk),
      .reset               (reset),
      .start_execute       (start_execute),
      .operation_execute   (operation_execute),
      .operand_a_execute   (operand_a_execute),
      .operand_b_execute   (operand_b_execute),
      .hi_write_execute    (hi_write_execute),
      .lo_write_execute    (lo_write_execute),
      .write_data_execute  (write_data_execute),
      .hi_lo_access_decode (hi_lo_access_decode),
      .hi                  (hi),
      .lo                  (lo),
      .busy                (busy),
      .stall_decode        (stall_decode),
      .clear_execute       (clear_execute)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] hi;
      logic [31:0] lo;
   } res_t;

   res_t        exp_q[$];
   int          n_chk = 0;
   int          n_fail = 0;
   logic        abort_pending = 1'b0;
   logic [31:0] m_hi = 32'd0;
   logic [31:0] m_lo = 32'd0;

   task automatic check(input string nm, input logic [31:0] act,
                        input logic [31:0] expv);
      n_chk++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
      end
   endtask

   // Reference: plain 64-bit arithmetic on the architectural meaning
   function automatic res_t ref_op(input logic [1:0] op,
                                   input logic [31:0] a, input logic [31:0] b);
      longint          sa, sb, sp, sq, sr;
      longint unsigned ua, ub, up, uq, ur;
      res_t            r;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'd0, a};
      ub = {32'd0, b};
      r  = '0;
      case (op)
         2'b00: begin sp = sa * sb; r.hi = sp[63:32]; r.lo = sp[31:0]; end
         2'b01: begin up = ua * ub; r.hi = up[63:32]; r.lo = up[31:0]; end
         default: begin
            if (b == 32'd0) begin
               r.hi = a;
               r.lo = 32'hFFFF_FFFF;
            end else if (op == 2'b10) begin
               sq = sa / sb; sr = sa % sb;
               r.lo = sq[31:0]; r.hi = sr[31:0];
            end else begin
               uq = ua / ub; ur = ua % ub;
               r.lo = uq[31:0]; r.hi = ur[31:0];
            end
         end
      endcase
      return r;
   endfunction

   // Monitor: a completed operation is a falling edge of busy
   int   bcnt = 0;
   logic pbusy = 1'b0;
   always @(negedge clk) begin
      res_t r;
      if (busy === 1'b1) begin
         bcnt++;
      end else if (pbusy === 1'b1) begin
         if (abort_pending) begin
            abort_pending = 1'b0;
         end else begin
            check("busy_len", 32'(bcnt), 32'd33);
            if (exp_q.size() == 0) begin
               check("sb_empty_on_done", 32'(exp_q.size()), 32'd1);
            end else begin
               r = exp_q.pop_front();
               check("res_hi", hi, r.hi);
               check("res_lo", lo, r.lo);
            end
         end
         bcnt = 0;
      end
      pbusy = busy;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue_exp(input logic [1:0] op, input logic [31:0] a,
                            input logic [31:0] b, input res_t e);
      start_execute     = 1'b1;
      operation_execute = op;
      operand_a_execute = a;
      operand_b_execute = b;
      exp_q.push_back(e);
      m_hi = e.hi;
      m_lo = e.lo;
      tick();
      start_execute = 1'b0;
   endtask

   task automatic issue(input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b);
      issue_exp(op, a, b, ref_op(op, a, b));
   endtask

   task automatic wait_idle();
      int k = 0;
      @(negedge clk);
      while (busy !== 1'b0 && k < 60) begin
         @(negedge clk);
         k++;
      end
      if (k >= 60) begin
         n_chk++;
         n_fail++;
         $display("FAIL idle_timeout: busy=%b still set after %0d cycles", busy, k);
      end
      tick();
   endtask

   initial begin
      logic [31:0] old_hi;
      logic [1:0]  op;
      logic [31:0] a, b;
      logic        e;
      reset               = 1'b1;
      start_execute       = 1'b0;
      operation_execute   = 2'b00;
      operand_a_execute   = 32'd0;
      operand_b_execute   = 32'd0;
      hi_write_execute    = 1'b0;
      lo_write_execute    = 1'b0;
      write_data_execute  = 32'd0;
      hi_lo_access_decode = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      check("rst_hi", hi, 32'd0);
      check("rst_lo", lo, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_stall", {31'd0, stall_decode}, 32'd0);
      check("rst_clear", {31'd0, clear_execute}, 32'd0);
      hi_lo_access_decode = 1'b0;

      // Directed cases with hand-derived results
      issue_exp(2'b00, 32'hFFFF_FFFD, 32'd5, {32'hFFFF_FFFF, 32'hFFFF_FFF1});
      wait_idle();
      issue_exp(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, {32'hFFFF_FFFE, 32'h0000_0001});
      wait_idle();
      issue_exp(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, {32'h0, 32'h1});
      wait_idle();
      issue_exp(2'b10, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
      wait_idle();
      issue_exp(2'b11, 32'd7, 32'd0, {32'd7, 32'hFFFF_FFFF});
      wait_idle();
      issue_exp(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000});
      wait_idle();
      check("idle_hi_hold", hi, m_hi);

      // Stall window, MTHI ignored while busy, HI held during CALC
      old_hi = m_hi;
      issue(2'b00, $urandom, $urandom);
      for (int k = 0; k < 37; k++) begin
         @(negedge clk);
         e = (k >= 5) && (k < 33);
         check("stall", {31'd0, stall_decode}, {31'd0, e});
         check("clear", {31'd0, clear_execute}, {31'd0, e});
         if (k == 10 || k == 32) check("hi_hold_busy", hi, old_hi);
         tick();
         hi_lo_access_decode = (k + 1 >= 5);
         hi_write_execute    = (k + 1 == 7);
         write_data_execute  = 32'h1234_5678;
      end
      hi_lo_access_decode = 1'b0;
      check("after_op_hi", hi, m_hi);

      // MTLO in IDLE
      lo_write_execute   = 1'b1;
      write_data_execute = 32'hCAFE_F00D;
      tick();
      lo_write_execute = 1'b0;
      check("mtlo_lo", lo, 32'hCAFE_F00D);
      check("mtlo_hi", hi, m_hi);

      // MTHI together with a start: write lands, result overwrites later
      hi_write_execute   = 1'b1;
      write_data_execute = 32'hAAAA_5555;
      issue_exp(2'b01, 32'd6, 32'd7, {32'd0, 32'd42});
      hi_write_execute = 1'b0;
      check("mthi_start_hi", hi, 32'hAAAA_5555);
      wait_idle();

      // Randomized operations against the reference
      for (int i = 0; i < 24; i++) begin
         op = 2'($urandom_range(3, 0));
         a  = $urandom;
         b  = $urandom;
         if ($urandom_range(7, 0) == 0) b = 32'd0;
         if ($urandom_range(3, 0) == 0) b = 32'($urandom_range(15, 1));
         if ($urandom_range(5, 0) == 0) a = 32'h8000_0000;
         issue(op, a, b);
         wait_idle();
      end

      // Reset in the middle of a DIV discards it
      issue(2'b10, 32'd1000, 32'd7);
      repeat (9) tick();
      abort_pending = 1'b1;
      void'(exp_q.pop_back());
      reset = 1'b1;
      tick();
      reset = 1'b0;
      hi_lo_access_decode = 1'b1;
      check("abort_busy", {31'd0, busy}, 32'd0);
      check("abort_hi", hi, 32'd0);
      check("abort_lo", lo, 32'd0);
      check("abort_stall", {31'd0, stall_decode}, 32'd0);
      check("abort_clear", {31'd0, clear_execute}, 32'd0);
      hi_lo_access_decode = 1'b0;
      issue_exp(2'b00, 32'd3, 32'd4, {32'd0, 32'd12});
      wait_idle();
      tick();

      check("sb_drain", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
